conv2d_crop: RTL
================

Name: conv2d_crop

Overview:
- Downstream of the 2-D convolution core; consumes its per-pixel result stream (pxl_ena_z / pxl_z).
- The core emits one result per input pixel, including partial-window positions on the left and top borders.
- This block tracks row/column position, drops the invalid border results, applies stride decimation, and emits only valid output-map pixels with end-of-line and end-of-frame markers for the write-back stage.

Parameters:
- C_WIDTH, 9, bit width of the width/height fields and of the position counters.
- KS, 3, convolution kernel size; the first KS-1 rows and columns of each frame are invalid.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- param_ena  input  1  1-cycle strobe; latches the frame parameters and re-arms the block.
- param_width_in  input  C_WIDTH  input-map width W (pixels per row).
- param_height_in  input  C_WIDTH  input-map height H (rows).
- param_stride  input  1  0 = stride 1, 1 = stride 2.
- pxl_ena_z  input  1  result valid from the convolution core; there is no backpressure.
- pxl_z  input  32  IEEE-754 single-precision result.
- out_ena  output  1  cropped pixel valid.
- out_data  output  32  cropped pixel.
- out_eol  output  1  with out_ena; last valid pixel of an output row.
- out_eof  output  1  with out_ena; last valid pixel of the frame.
- frame_done  output  1  1-cycle pulse after the last input result of the frame.
- err_unarmed  output  1  sticky; pxl_ena_z seen while not armed.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; col, row, W, H and stride cleared.
  - All outputs 0, including err_unarmed.
- States: IDLE, ARMED, RUN.
  - IDLE -> ARMED on param_ena: latch W, H and stride; clear col/row.
  - ARMED -> RUN on the first pxl_ena_z. That result is processed as col=0, row=0.
  - RUN: each pxl_ena_z advances col. When col=W-1, col wraps to 0 and row increments.
  - The result at col=W-1, row=H-1 is processed, then frame_done pulses the next cycle and state returns to ARMED with col=row=0. Back-to-back frames need no new param_ena.
- param_ena in any state: re-latch the parameters, clear col/row, go to ARMED. Any result on the same cycle is discarded.
- Keep rule, for a result at (col,row): keep iff col>=KS-1 and row>=KS-1, and, if stride=1, (col-(KS-1)) and (row-(KS-1)) are both even.
- Output timing:
  - A kept result appears on out_data with out_ena=1 exactly 1 cycle after its pxl_ena_z.
  - out_data holds its last value when out_ena=0.
- Markers:
  - out_eol=1 iff this is the last kept column of the row: col=W-1 for stride 1; for stride 2, the largest kept col <= W-1.
  - out_eof=1 iff out_eol=1 and this is the last kept row.
- Output count per frame: Wo*Ho.
  - Stride 1: Wo = W-KS+1.
  - Stride 2: Wo = floor((W-KS)/2)+1.
  - Ho is computed the same way from H.
- Degenerate sizes: if W<KS or H<KS, nothing is emitted; frame_done still pulses after W*H results. W=0 or H=0 is treated as 1.
- pxl_ena_z in IDLE: ignored and sets err_unarmed, which is cleared only by reset.
- rst_n low mid-frame: immediate return to IDLE; a pending out_ena is cancelled on the next edge.
- Counters are C_WIDTH wide; the compare is against the latched W-1 and H-1, so no overflow occurs for W,H <= 2^C_WIDTH-1.

Optional Feature:
- Macro: CONV2D_CROP_RELU_EN.
- Defined: a kept result with sign bit 1 is output as 32'h0000_0000; -0.0 (32'h8000_0000) also becomes +0.0. Latency is unchanged at 1 cycle.
- Undefined: kept results pass through bit-exact.

Test Plan:
- W=5, H=5, stride=0, KS=3, 25 results with pxl_z=index -> 9 outputs, values 12,13,14,17,18,19,22,23,24.
  - out_eol on 14, 19, 24; out_eof on 24; frame_done 1 cycle after result 24.
- W=6, H=6, stride=1, 36 results with pxl_z=index -> 4 outputs, values 14,16,26,28.
  - out_eol on 16 and 28; out_eof on 28.
- W=4, H=4 frame with pxl_ena_z toggling 1010... -> same kept indices as a contiguous stream.
  - Each output arrives exactly 1 cycle after its input.
- pxl_ena_z before any param_ena -> no out_ena, err_unarmed=1; it stays 1 after a later param_ena and clears only on rst_n=0.
- param_ena asserted after 10 of 25 results -> counters restart; the next 25 results produce exactly 9 outputs. Separately, rst_n low mid-frame -> all outputs 0 on the next cycle.
- With CONV2D_CROP_RELU_EN: kept pxl_z=32'hBF80_0000 (-1.0) -> out_data 32'h0; 32'h3F80_0000 -> unchanged. Without the macro: both pass through unchanged.

Source files
------------

// File: rtl/conv2d_crop_if.sv
// Pixel streams around conv2d_crop: the result stream from the
// convolution core and the cropped output stream to write-back.
interface conv2d_crop_if;
    logic        pxl_ena_z;
    logic [31:0] pxl_z;
    logic        out_ena;
    logic [31:0] out_data;
    logic        out_eol;
    logic        out_eof;

    modport master (
        output pxl_ena_z, pxl_z,
        input  out_ena, out_data, out_eol, out_eof
    );

    modport slave (
        input  pxl_ena_z, pxl_z,
        output out_ena, out_data, out_eol, out_eof
    );
endinterface

// File: rtl/conv2d_crop.sv
// Crops border results of the conv core, applies stride decimation, tags EOL/EOF.
// Optional macro CONV2D_CROP_RELU_EN clamps negative kept results to +0.0.
module conv2d_crop #(
    parameter int C_WIDTH = 9,
    parameter int KS      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               param_ena,
    input  logic [C_WIDTH-1:0] param_width_in,
    input  logic [C_WIDTH-1:0] param_height_in,
    input  logic               param_stride,
    conv2d_crop_if.slave       bus,
    output logic               frame_done,
    output logic               err_unarmed
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    localparam logic [C_WIDTH-1:0] KM1 = C_WIDTH'(KS - 1);
    localparam logic [C_WIDTH:0]   ONE = (C_WIDTH+1)'(1);

    state_t             state_q, state_d;
    logic [C_WIDTH-1:0] col_q, col_d;
    logic [C_WIDTH-1:0] row_q, row_d;
    logic [C_WIDTH-1:0] wm1_q, wm1_d;
    logic [C_WIDTH-1:0] hm1_q, hm1_d;
    logic               stride_q, stride_d;
    logic               ena_q, ena_d;
    logic [31:0]        data_q, data_d;
    logic               eol_q, eol_d;
    logic               eof_q, eof_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               take;
    logic               keep;
    logic               col_eol;
    logic               row_eof;
    logic               col_last;
    logic               row_last;
    logic [C_WIDTH-1:0] col_off;
    logic [C_WIDTH-1:0] row_off;
    logic [31:0]        pxl_out;

    always_comb begin
        col_off  = col_q - KM1;
        row_off  = row_q - KM1;
        col_last = (col_q == wm1_q);
        row_last = (row_q == hm1_q);
        keep = (col_q >= KM1) && (row_q >= KM1) &&
               (!stride_q || (!col_off[0] && !row_off[0]));
        // stride 2: if W-1 itself is off-grid, the kept column just before it ends the row
        col_eol = col_last ||
                  (stride_q && ({1'b0, col_q} + ONE == {1'b0, wm1_q}));
        row_eof = row_last ||
                  (stride_q && ({1'b0, row_q} + ONE == {1'b0, hm1_q}));
        take = bus.pxl_ena_z && !param_ena && (state_q != IDLE);
    end

`ifdef CONV2D_CROP_RELU_EN
    assign pxl_out = bus.pxl_z[31] ? 32'h0000_0000 : bus.pxl_z;
`else
    assign pxl_out = bus.pxl_z;
`endif

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        wm1_d    = wm1_q;
        hm1_d    = hm1_q;
        stride_d = stride_q;
        ena_d    = 1'b0;
        data_d   = data_q;
        eol_d    = 1'b0;
        eof_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q | (bus.pxl_ena_z && (state_q == IDLE));

        if (param_ena) begin
            state_d  = ARMED;
            col_d    = '0;
            row_d    = '0;
            wm1_d    = (param_width_in == '0) ? '0 : param_width_in - 1'b1;
            hm1_d    = (param_height_in == '0) ? '0 : param_height_in - 1'b1;
            stride_d = param_stride;
        end else if (take) begin
            state_d = RUN;
            ena_d   = keep;
            eol_d   = keep && col_eol;
            eof_d   = keep && col_eol && row_eof;
            if (keep) begin
                data_d = pxl_out;
            end
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d   = '0;
                    state_d = ARMED;
                    done_d  = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            wm1_q    <= '0;
            hm1_q    <= '0;
            stride_q <= 1'b0;
            ena_q    <= 1'b0;
            data_q   <= '0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            wm1_q    <= wm1_d;
            hm1_q    <= hm1_d;
            stride_q <= stride_d;
            ena_q    <= ena_d;
            data_q   <= data_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_ena  = ena_q;
    assign bus.out_data = data_q;
    assign bus.out_eol  = eol_q;
    assign bus.out_eof  = eof_q;
    assign frame_done   = done_q;
    assign err_unarmed  = err_q;

endmodule
